multicycle_control: RTL and testbench

- Moore FSM that sequences the shared 32-bit ALU, instruction/data memory, register file and PC of the multicycle MIPS-subset datapath.
- Decodes Op/Funct from the instruction register.
- Drives mux selects, write enables and the 3-bit ALUControl, one instruction at a time.
- Sits beside the datapath top level. It takes Zero back from the ALU and resolves branches.

---
 rtl/multicycle_control.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit.
// Moore FSM that sequences the shared ALU, memory, register file and PC.
// Op and Funct come live from the instruction register. They are not latched here,
// because the datapath keeps them stable from DECODE until the next FETCH.
module multicycle_control #(
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_r;
    logic        op_ok_s;
    logic        rtype_ok_s;
    logic [2:0]  rtype_alu_s;
    logic        illegal_s;

    logic        iord_s;
    logic        memwrite_s;
    logic        irwrite_s;
    logic        regdst_s;
    logic        memtoreg_s;
    logic        regwrite_s;
    logic        alusrca_s;
    logic [1:0]  alusrcb_s;
    logic [2:0]  alucontrol_s;
    logic [1:0]  pcsrc_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic        instrdone_s;

    // Identify the opcodes this control unit knows how to sequence.
    always_comb begin
        case (Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok_s = 1'b1;
            default:                                       op_ok_s = 1'b0;
        endcase
    end

    // Map R-type Funct to an ALU operation and flag the unsupported codes.
    always_comb begin
        rtype_ok_s  = 1'b1;
        rtype_alu_s = 3'b010;
        case (Funct)
            6'b100000: rtype_alu_s = 3'b010;
            6'b100010: rtype_alu_s = 3'b110;
            6'b100100: rtype_alu_s = 3'b000;
            6'b100101: rtype_alu_s = 3'b001;
            6'b101010: rtype_alu_s = 3'b111;
            6'b100111: rtype_alu_s = 3'b100;
            default: begin
                rtype_ok_s  = 1'b0;
                rtype_alu_s = 3'b010;
            end
        endcase
    end

    assign illegal_s = ~op_ok_s | ((Op == OP_RTYPE) & ~rtype_ok_s);

    // State register with next-state selection; HALT is left only through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:   state_r <= S_DECODE;
                S_DECODE: begin
                    if (illegal_s) begin
                        state_r <= TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end else begin
                        case (Op)
                            OP_LW, OP_SW: state_r <= S_MEMADR;
                            OP_RTYPE:     state_r <= S_EXECUTE;
                            OP_BEQ:       state_r <= S_BRANCH;
                            OP_ADDI:      state_r <= S_ADDIEX;
                            OP_J:         state_r <= S_JUMP;
                            default:      state_r <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:  state_r <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   state_r <= S_MEMWB;
                S_EXECUTE: state_r <= S_ALUWB;
                S_ADDIEX:  state_r <= S_ADDIWB;
                S_HALT:    state_r <= S_HALT;
                default:   state_r <= S_FETCH;
            endcase
        end
    end

    // Moore decode of datapath controls from the current state.
    always_comb begin
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        alucontrol_s = 3'b010;
        pcsrc_s      = 2'b00;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        instrdone_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                alusrcb_s = 2'b01;
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_MEMRD: begin
                iord_s = 1'b1;
            end
            S_MEMWB: begin
                memtoreg_s  = 1'b1;
                regwrite_s  = 1'b1;
                instrdone_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s      = 1'b1;
                memwrite_s  = 1'b1;
                instrdone_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_s    = 1'b1;
                alucontrol_s = rtype_alu_s;
            end
            S_ALUWB: begin
                regdst_s    = 1'b1;
                regwrite_s  = 1'b1;
                instrdone_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s    = 1'b1;
                alucontrol_s = 3'b110;
                pcsrc_s      = 2'b01;
                branch_s     = 1'b1;
                instrdone_s  = 1'b1;
            end
            S_ADDIWB: begin
                regwrite_s  = 1'b1;
                instrdone_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc_s     = 2'b10;
                pcwrite_s   = 1'b1;
                instrdone_s = 1'b1;
            end
            default: begin
                alucontrol_s = 3'b010;
            end
        endcase
    end

    // Write enables are gated by reset so an interrupted store or writeback never commits.
    assign IorD       = iord_s;
    assign MemWrite   = memwrite_s & ~reset;
    assign IRWrite    = irwrite_s & ~reset;
    assign RegDst     = regdst_s;
    assign MemtoReg   = memtoreg_s;
    assign RegWrite   = regwrite_s & ~reset;
    assign ALUSrcA    = alusrca_s;
    assign ALUSrcB    = alusrcb_s;
    assign ALUControl = alucontrol_s;
    assign PCSrc      = pcsrc_s;
    assign PCEn       = (pcwrite_s | (branch_s & Zero)) & ~reset;
    assign InstrDone  = instrdone_s;
    assign Illegal    = (state_r == S_DECODE) & illegal_s;
    assign State      = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// The reference model works per instruction. It expands each instruction class into
// its list of phase codes. Each phase then gets its controls from a table of the
// non-default settings.
module tb_multicycle_control;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWR = 5, ST_EXECUTE = 6, ST_ALUWB = 7, ST_BRANCH = 8;
    localparam int ST_ADDIEX = 9, ST_ADDIWB = 10, ST_JUMP = 11, ST_HALT = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    wire [20:0] v0;
    wire [20:0] v1;

    int checks = 0;
    int errors = 0;

    logic [16:0] tab [0:15];
    logic [5:0]  rfun [0:5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [2:0]  ralu [0:5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100};
    int          seq [$];

    always #5 clk = ~clk;

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(v0[16]), .MemWrite(v0[15]), .IRWrite(v0[14]), .RegDst(v0[13]),
        .MemtoReg(v0[12]), .RegWrite(v0[11]), .ALUSrcA(v0[10]), .ALUSrcB(v0[9:8]),
        .ALUControl(v0[7:5]), .PCSrc(v0[4:3]), .PCEn(v0[2]), .InstrDone(v0[1]),
        .Illegal(v0[0]), .State(v0[20:17])
    );

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(v1[16]), .MemWrite(v1[15]), .IRWrite(v1[14]), .RegDst(v1[13]),
        .MemtoReg(v1[12]), .RegWrite(v1[11]), .ALUSrcA(v1[10]), .ALUSrcB(v1[9:8]),
        .ALUControl(v1[7:5]), .PCSrc(v1[4:3]), .PCEn(v1[2]), .InstrDone(v1[1]),
        .Illegal(v1[0]), .State(v1[20:17])
    );

    // Table word: iord, mw, irw, rd, m2r, rw, srca, srcb[2], alu[3], pcsrc[2], pcwrite, branch, done
    function automatic logic [16:0] mk(input logic iord, mw, irw, rd, m2r, rw, srca,
                                       input logic [1:0] srcb, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic pcw, br, done);
        return {iord, mw, irw, rd, m2r, rw, srca, srcb, alu, pcs, pcw, br, done};
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        for (int i = 0; i < 6; i++) if (rfun[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        for (int i = 0; i < 6; i++) if (rfun[i] == f) return ralu[i];
        return 3'b010;
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f);
        if (op == 6'b000000) return funct_ok(f);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
               (op == 6'b001000) || (op == 6'b000010);
    endfunction

    // Expand one instruction into the phase codes it should visit.
    function automatic void plan(input logic [5:0] op, input logic [5:0] f);
        seq = '{ST_FETCH, ST_DECODE};
        if (is_legal(op, f)) begin
            case (op)
                6'b100011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMRD); seq.push_back(ST_MEMWB); end
                6'b101011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWR); end
                6'b000000: begin seq.push_back(ST_EXECUTE); seq.push_back(ST_ALUWB); end
                6'b000100: seq.push_back(ST_BRANCH);
                6'b001000: begin seq.push_back(ST_ADDIEX); seq.push_back(ST_ADDIWB); end
                default:   seq.push_back(ST_JUMP);
            endcase
        end
    endfunction

    function automatic logic [20:0] expect_vec(input int s, input logic [5:0] op, input logic [5:0] f,
                                               input logic z, input logic rst);
        logic [16:0] t;
        logic [2:0]  alu;
        logic        pcen;
        logic        ill;
        t    = tab[s];
        alu  = (s == ST_EXECUTE) ? funct_alu(f) : t[7:5];
        pcen = (t[2] | (t[1] & z)) & ~rst;
        ill  = (s == ST_DECODE) && !is_legal(op, f);
        return {4'(s), t[16], t[15] & ~rst, t[14] & ~rst, t[13], t[12], t[11] & ~rst,
                t[10], t[9:8], alu, t[4:3], pcen, t[0], ill};
    endfunction

    task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // zmode: 0/1 force Zero, 2 randomises it every cycle; rst_at asserts reset in that phase.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                             input int rst_at, input string tag);
        int  done_cnt;
        bit  hit_rst;
        done_cnt = 0;
        hit_rst  = 1'b0;
        plan(op, f);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                Op    = op;
                Funct = f;
            end
            Zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            reset = (i == rst_at);
            #1;
            check(tag, v0, expect_vec(seq[i], op, f, Zero, reset));
            if (v0[1] === 1'b1) done_cnt++;
            if (i == rst_at) begin
                hit_rst = 1'b1;
                break;
            end
        end
        if (!hit_rst) begin
            checks++;
            assert (done_cnt == (is_legal(op, f) ? 1 : 0)) else begin
                errors++;
                $error("FAIL %s_done: observed %0d InstrDone cycles expected %0d",
                       tag, done_cnt, is_legal(op, f) ? 1 : 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            tab[i] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0);
        tab[ST_FETCH]   = mk(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0);
        tab[ST_DECODE]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 0);
        tab[ST_MEMADR]  = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
        tab[ST_ADDIEX]  = tab[ST_MEMADR];
        tab[ST_MEMRD]   = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0);
        tab[ST_MEMWB]   = mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1);
        tab[ST_MEMWR]   = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1);
        tab[ST_EXECUTE] = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0, 0);
        tab[ST_ALUWB]   = mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1);
        tab[ST_BRANCH]  = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 1, 1);
        tab[ST_ADDIWB]  = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0, 1);
        tab[ST_JUMP]    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1, 0, 1);

        reset = 1'b1;
        Op    = 6'b000000;
        Funct = 6'b100000;
        Zero  = 1'b0;

        // Reset held two cycles: FETCH code with its enables gated off.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("reset_state", v0, expect_vec(ST_FETCH, Op, Funct, Zero, 1'b1));
        end

        // Directed instructions.
        run_instr(6'b100011, 6'($urandom), 2, -1, "lw");
        run_instr(6'b000000, 6'b101010, 2, -1, "rtype_slt");
        run_instr(6'b000000, 6'b100111, 2, -1, "rtype_nor");
        run_instr(6'b000100, 6'($urandom), 1, -1, "beq_taken");
        run_instr(6'b000100, 6'($urandom), 0, -1, "beq_not_taken");
        run_instr(6'b101011, 6'($urandom), 2, 3, "sw_reset_in_memwr");
        run_instr(6'b001000, 6'($urandom), 2, -1, "addi");
        run_instr(6'b000010, 6'($urandom), 2, -1, "jump");
        run_instr(6'b111111, 6'($urandom), 2, -1, "illegal_op");
        run_instr(6'b000000, 6'b000000, 2, -1, "illegal_funct");
        run_instr(6'b101011, 6'($urandom), 2, -1, "sw");

        // Trapping variant: illegal opcode parks in HALT until reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Op    = 6'b111111;
        Funct = 6'b100000;
        Zero  = 1'b1;
        #1;
        check("trap_fetch", v1, expect_vec(ST_FETCH, Op, Funct, Zero, 1'b0));
        @(negedge clk);
        #1;
        check("trap_decode", v1, expect_vec(ST_DECODE, Op, Funct, Zero, 1'b0));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            Op   = 6'($urandom);
            Zero = 1'($urandom_range(0, 1));
            #1;
            check("trap_halt", v1, expect_vec(ST_HALT, Op, Funct, Zero, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("trap_halt_in_reset", v1, expect_vec(ST_HALT, Op, Funct, Zero, 1'b1));
        @(negedge clk);
        #1;
        check("trap_reset_exit", v1, expect_vec(ST_FETCH, Op, Funct, Zero, 1'b1));

        // Randomised instruction stream on the non-trapping unit.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic [5:0] f;
            int         rst_at;
            f      = rfun[$urandom_range(0, 5)];
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            case ($urandom_range(0, 7))
                0:       op = 6'b100011;
                1:       op = 6'b101011;
                2:       op = 6'b000000;
                3:       op = 6'b000100;
                4:       op = 6'b001000;
                5:       op = 6'b000010;
                6: begin
                    op = 6'($urandom);
                    if (is_legal(op, f)) op = 6'b111111;
                end
                default: begin
                    op = 6'b000000;
                    f  = 6'($urandom);
                end
            endcase
            run_instr(op, f, 2, rst_at, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
